// File: rtl/btn_pulse_pkg.sv
// Shared types for the button pulse generator.
// State encoding, press modes and counter sizing.
package btn_pulse_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS,
    HOLD,
    REPEAT,
    WAIT_RELEASE
  } state_e;

  typedef enum logic {
    MODE_SINGLE = 1'b0,
    MODE_REPEAT = 1'b1
  } mode_e;

  // Bits needed to hold 0..max_cnt, never narrower than one bit.
  function automatic int cnt_w(input int max_cnt);
    return (max_cnt < 1) ? 1 : $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: 2-flop synchroniser, debouncer,
// and press/hold/repeat FSM with registered outputs.
module btn_channel
  import btn_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_CYC     = 20,
  parameter int REPEAT_CYC   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic button_i,
  input  logic mode_i,
  output logic pulse_o,
  output logic held_o
);

  localparam int DW = cnt_w(DEBOUNCE_CYC);
  localparam int HW = cnt_w(HOLD_CYC);
  localparam int RW = cnt_w(REPEAT_CYC - 1);

  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] HLD_LAST = HW'(HOLD_CYC);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          db_q, db_d;
  logic [DW-1:0] db_cnt_q, db_cnt_d;
  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;
  logic          pulse_q, pulse_d;
  logic          held_q, held_d;

  // Shift the raw level into the synchroniser.
  always_comb begin
    sync_d = {sync_q[0], button_i};
  end

  // Accept a level change only after DEBOUNCE_CYC differing samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    if (sync_q[1] == db_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q >= DB_LAST) begin
      db_d     = sync_q[1];
      db_cnt_d = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  // Press FSM; pulse/held are decided here and registered.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    pulse_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
        if (db_q) begin
          state_d = PRESS;
          mode_d  = mode_e'(mode_i);
        end
      end
      PRESS: begin
        pulse_d    = 1'b1;
        hold_cnt_d = '0;
        state_d    = db_q ? HOLD : IDLE;
      end
      HOLD: begin
        if (!db_q) begin
          state_d = IDLE;
        end else if (hold_cnt_q >= HLD_LAST) begin
          rep_cnt_d = '0;
          if (mode_q == MODE_REPEAT) begin
            state_d = REPEAT;
            pulse_d = 1'b1;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      REPEAT: begin
        if (!db_q) begin
          state_d = IDLE;
        end else if (rep_cnt_q >= REP_LAST) begin
          pulse_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + 1'b1;
        end
      end
      WAIT_RELEASE: begin
        if (!db_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    held_d = state_d inside {REPEAT, WAIT_RELEASE};
  end

  // All channel state, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      db_q       <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      mode_q     <= MODE_SINGLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      pulse_q    <= 1'b0;
      held_q     <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      db_q       <= db_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      mode_q     <= mode_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      pulse_q    <= pulse_d;
      held_q     <= held_d;
    end
  end

  assign pulse_o = pulse_q;
  assign held_o  = held_q;

endmodule

// File: rtl/btn_pulse_gen.sv
// N_CH independent debounced button channels producing
// press/auto-repeat pulses and a long-press level.
module btn_pulse_gen
  import btn_pulse_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int DEBOUNCE_CYC = 4,
  parameter int HOLD_CYC     = 20,
  parameter int REPEAT_CYC   = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [N_CH-1:0] button_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] pulse_o,
  output logic [N_CH-1:0] held_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .HOLD_CYC    (HOLD_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .button_i(button_i[i]),
      .mode_i  (mode_i[i]),
      .pulse_o (pulse_o[i]),
      .held_o  (held_o[i])
    );
  end

endmodule

// File: doc/btn_pulse_gen.md
BTN_PULSE_GEN -- requirements
Module: btn_pulse_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 Parameter DEBOUNCE_CYC, default 4: consecutive stable cycles required to accept a level change, >=1.
REQ-003 Parameter HOLD_CYC, default 20: held cycles after the press pulse before long-press/repeat begins, >=1.
REQ-004 Parameter REPEAT_CYC, default 8: period between auto-repeat pulses, >=1.
REQ-005 clk_i  input  1  single clock; all logic SHALL be on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 button_i  input  N_CH  raw asynchronous button levels, 1 = pressed.
REQ-008 mode_i  input  N_CH  per-channel mode: 0 = single pulse per press, 1 = auto-repeat.
REQ-009 pulse_o  output  N_CH  one-cycle press/repeat pulses, registered.
REQ-010 held_o  output  N_CH  long-press level, registered.

Function
REQ-011 Each channel SHALL pass button_i through a 2-flop synchroniser before any other logic.
REQ-012 The debouncer SHALL keep a debounced level db and a counter that clears whenever the synchronised level equals db, and increments otherwise.
REQ-013 db SHALL take the synchronised level on the edge at which the counter would reach DEBOUNCE_CYC; a single differing sample shorter than DEBOUNCE_CYC SHALL leave db unchanged.
REQ-014 Counter widths SHALL be $clog2(max count + 1) bits; counters SHALL saturate, never wrap.
REQ-015 FSM states per channel: IDLE, PRESS, HOLD, REPEAT, WAIT_RELEASE.
REQ-016 IDLE -> PRESS on db rising; PRESS lasts exactly one cycle and asserts pulse_o.
REQ-017 PRESS -> HOLD if db still 1; PRESS -> IDLE if db 0.
REQ-018 mode_i SHALL be latched on entry to PRESS; changes while pressed SHALL be ignored until the next press.
REQ-019 HOLD counts HOLD_CYC cycles; on expiry, mode 1 -> REPEAT with a pulse_o on the expiry cycle; mode 0 -> WAIT_RELEASE.
REQ-020 REPEAT SHALL assert pulse_o for one cycle every REPEAT_CYC cycles while db = 1.
REQ-021 held_o SHALL be 1 in REPEAT and WAIT_RELEASE and 0 in all other states.
REQ-022 db falling in any state SHALL return that channel to IDLE on the next edge, clearing counters, pulse_o and held_o.
REQ-023 Latency: for raw high first sampled at edge k and held stable, the first pulse_o cycle SHALL begin at edge k+DEBOUNCE_CYC+3.
REQ-024 Channels SHALL be fully independent; simultaneous presses on any subset SHALL produce simultaneous pulses.
REQ-025 pulse_o SHALL never be high on two consecutive cycles when REPEAT_CYC >= 2; when REPEAT_CYC = 1 it SHALL stay high continuously in REPEAT.

Reset
REQ-026 When rst_i = 1 at an edge, all synchronisers, db, counters and FSMs SHALL clear to 0/IDLE; pulse_o = 0 and held_o = 0 from that edge on.
REQ-027 Reset mid-press SHALL NOT generate a pulse on release; a button still held when reset deasserts SHALL produce one press pulse after the normal debounce latency.

Structure
REQ-028 Package btn_pulse_pkg SHALL hold the state enum and the mode typedef (MODE_SINGLE, MODE_REPEAT).
REQ-029 Sub-module btn_channel SHALL hold one channel's synchroniser, debouncer and FSM; btn_pulse_gen SHALL instantiate N_CH of them in a generate loop.

Verification (N_CH=4, DEBOUNCE_CYC=4, HOLD_CYC=20, REPEAT_CYC=8)
REQ-030 Ch0 mode 0, clean press for 10 cycles -> one pulse_o[0] at edge k+7, held_o[0] stays 0, no pulse on release.
REQ-031 Ch1 raw bounce 1,0,1,0,1 then stable high 30 cycles, mode 0 -> exactly one pulse, held_o[1] high from HOLD expiry until release.
REQ-032 Ch2 mode 1 held for 60 cycles after the press pulse -> pulses at press, +21, +29, +37, +45, +53 cycles; held_o[2] high from +21.
REQ-033 3-cycle glitch high on ch3 -> no pulse, db unchanged.
REQ-034 All four channels pressed on the same edge -> pulse_o = 4'b1111 for one cycle; mode_i toggled mid-hold has no effect.
REQ-035 rst_i asserted mid-REPEAT for 2 cycles with button still held -> outputs 0 during reset, then one press pulse 7 cycles after release of rst_i.
